// File: rtl/score_pkg.sv
// Shared types and the BCD-to-seven-segment lookup for the score display path.
package score_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg_t;   // {g,f,e,d,c,b,a}, active-high

    localparam seg_t SEG_DASH  = 7'h40;
    localparam seg_t SEG_BLANK = 7'h00;

    function automatic seg_t bcd_to_seg(input bcd_digit_t digit);
        case (digit)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return SEG_DASH;   // non-BCD nibble
        endcase
    endfunction

endpackage

// File: rtl/score_display_mux_seg7_decode.sv
// Combinational nibble to seven-segment decoder; non-BCD nibbles show a dash.
module seg7_decode
    import score_pkg::*;
(
    input  bcd_digit_t digit,
    output seg_t       seg
);

    assign seg = bcd_to_seg(digit);

endmodule

// File: rtl/score_display_mux.sv
// Time-multiplexed 4-digit score display with per-frame snapshot, leading-zero
// blanking and game-over blink. Optional high-score feature: SCORE_DISPLAY_HISCORE_EN.
module score_display_mux
    import score_pkg::*;
#(
    parameter int REFRESH_DIV = 1024,
    parameter int BLINK_LOG2  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score,
    input  logic        game_over,
`ifdef SCORE_DISPLAY_HISCORE_EN
    input  logic        show_hi,
`endif
    output seg_t        seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]    slot_cnt;
    logic [1:0]          digit_idx;
    logic [15:0]         snap;
    logic                snap_valid;
    logic [BLINK_LOG2:0] blink_cnt;

    logic        slot_wrap, frame_wrap, load_snap, blink_off, view_hi;
    logic [15:0] snap_src, view;
    logic [3:0]  lead_zero;
    bcd_digit_t  cur_digit;
    seg_t        dec_seg, next_seg;
    logic [3:0]  next_an;
    logic        next_dp;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_wrap = slot_wrap && (digit_idx == 2'd3);
    // snap_valid is low only on the first clock after reset, forcing a load.
    assign load_snap  = frame_wrap || !snap_valid;
    assign view       = snap_valid ? snap : snap_src;
    assign blink_off  = game_over && blink_cnt[BLINK_LOG2];

`ifdef SCORE_DISPLAY_HISCORE_EN
    logic [15:0] hi;
    logic        go_q;
    logic        snap_hi;

    assign snap_src = show_hi ? hi : score;
    assign view_hi  = snap_valid ? snap_hi : show_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi      <= '0;
            go_q    <= 1'b0;
            snap_hi <= 1'b0;
        end else begin
            go_q <= game_over;
            if (game_over && !go_q && (score > hi))
                hi <= score;
            if (load_snap)
                snap_hi <= show_hi;
        end
    end
`else
    assign snap_src = score;
    assign view_hi  = 1'b0;
`endif

    // A digit is a leading zero when it and every higher digit are zero.
    assign lead_zero[3] = (view[15:12] == 4'd0);
    assign lead_zero[2] = lead_zero[3] && (view[11:8] == 4'd0);
    assign lead_zero[1] = lead_zero[2] && (view[7:4] == 4'd0);
    assign lead_zero[0] = 1'b0;

    assign cur_digit = view[{digit_idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_seg = SEG_BLANK;
        next_an  = 4'b0000;
        next_dp  = 1'b0;
        if (!blink_off) begin
            next_an  = 4'b0001 << digit_idx;
            next_seg = lead_zero[digit_idx] ? SEG_BLANK : dec_seg;
            next_dp  = view_hi && (digit_idx == 2'd0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt   <= '0;
            digit_idx  <= 2'd0;
            snap       <= '0;
            snap_valid <= 1'b0;
            blink_cnt  <= '0;
            seg        <= SEG_BLANK;
            an         <= 4'b0000;
            dp         <= 1'b0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap)
                digit_idx <= digit_idx + 2'd1;
            if (load_snap) begin
                snap       <= snap_src;
                snap_valid <= 1'b1;
            end
            // Counter idles at zero so a new game_over always opens with an on phase.
            if (!game_over)
                blink_cnt <= '0;
            else if (frame_wrap)
                blink_cnt <= blink_cnt + 1'b1;
            seg <= next_seg;
            an  <= next_an;
            dp  <= next_dp;
        end
    end

endmodule
